id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage ARM-subset pipeline, directly downstream of instruction fetch.
- Consumes the fetched instruction and PC+4 and reads the 16x32 register file, with write-back port and write-through bypass.
- Decodes control, evaluates the condition field against the status flags, and drives a registered ID/EX pipeline boundary with freeze, flush and bubble insertion.
- Source-register indices are also exported combinationally to the hazard unit.

Parameters:
- NREGS, 16, register-file depth (index width 4).
- XLEN, 32, datapath width.

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- freeze  in  1  hold ID/EX register contents
- flush  in  1  branch taken; load bubble into ID/EX register
- hazard  in  1  from hazard unit; decode current instruction as bubble
- pc_in  in  32  PC+4 from fetch
- instruction  in  32  fetched instruction
- sr  in  4  status flags {N,Z,C,V}
- wb_en  in  1  register write-back enable
- wb_dest  in  4  write-back register index
- wb_value  in  32  write-back data
- src1  out  4  Rn = instruction[19:16], combinational
- src2  out  4  mem_w ? Rd : Rm (instruction[3:0]), combinational
- two_src  out  1  (~I) | mem_w, combinational
- pc_out  out  32  registered pc_in
- val_rn, val_rm  out  32 each  registered operands; val_rm reads src2
- exe_cmd  out  4  registered ALU command
- mem_r_en, mem_w_en, wb_en_out, s_out, b_out, imm_out  out  1 each  registered controls
- shift_operand  out  12  registered instruction[11:0]
- signed_imm_24  out  24  registered instruction[23:0]
- dest  out  4  registered Rd = instruction[15:12]

Behaviour:
- Fields: cond[31:28], mode[27:26], I[25], opcode[24:21], S/L[20].
- mode 00 is data processing; mode 01 is memory (L=1 LDR, L=0 STR); mode 10 is branch.
- exe_cmd map:
  - MOV 1101->0001, MVN 1111->1001
  - ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101
  - AND 0000->0110, ORR 1100->0111, EOR 0001->1000
  - CMP 1010->0100, TST 1000->0110
  - LDR/STR->0010; others->0000.
- wb_en_out: set for data-processing except CMP/TST, and for LDR. Clear for STR and B.
- s_out: S for data-processing, 0 for memory (LDR and STR), 0 for B.
- b_out: mode 10. mem_r_en: LDR. mem_w_en: STR.
- Condition codes:
  - 0000 EQ Z, 0001 NE ~Z, 0010 CS C, 0011 CC ~C
  - 0100 MI N, 0101 PL ~N, 0110 VS V, 0111 VC ~V
  - 1000 HI C&~Z, 1001 LS ~C|Z
  - 1010 GE N==V, 1011 LT N!=V, 1100 GT ~Z&(N==V), 1101 LE Z|(N!=V)
  - 1110 AL 1, 1111 0.
- Bubble: if the condition fails or hazard=1, the controls exe_cmd, mem_r_en, mem_w_en, wb_en_out, s_out, b_out are zeroed before registering. Data fields still load.
- Register file:
  - Written at the rising edge when wb_en=1. R15 is also writable.
  - Reads are combinational.
  - Bypass: if wb_en and wb_dest matches a read index in the same cycle, that read returns wb_value.
- ID/EX register priority is rst > flush > freeze > load.
  - flush loads all zeros, including pc_out.
  - freeze holds all outputs.
  - flush+freeze together: flush wins.
- Register-file writes occur regardless of freeze or flush.
- Latency: the instruction presented in cycle n appears on the registered outputs after edge n+1.
- Reset (rst=0, async): all registered outputs and all 16 registers are 0. Combinational outputs follow the instruction input.
- Reset asserted mid-operation discards in-flight state immediately. First load occurs on the first rising edge after rst returns to 1.

Test Plan:
- Reset: rst=0 with instruction=0xE3A01005 -> all registered outputs 0; after release and one edge, exe_cmd=0001, wb_en_out=1, imm_out=1, dest=1, shift_operand=0x005.
- Write-back and bypass: wb_en=1, wb_dest=2, wb_value=0x1234, instruction=0xE0821003 (ADD R1,R2,R3) -> same-cycle val_rn path=0x1234; next edge val_rn=0x1234, exe_cmd=0010.
- Condition fail: sr=0000, instruction=0x03A01005 (MOVEQ) -> exe_cmd=0, wb_en_out=0, dest=1.
- Condition pass: with sr=0100 the same instruction -> wb_en_out=1.
- STR: instruction=0xE5821000 -> mem_w_en=1, wb_en_out=0, exe_cmd=0010, src2=1, two_src=1.
- CMP: instruction=0xE1520003 -> exe_cmd=0100, s_out=1, wb_en_out=0.
- Freeze/flush:
  - Hold freeze=1 for 2 cycles while the instruction changes -> outputs unchanged.
  - Raise flush=1 together with freeze=1 -> all registered outputs 0 next edge.
  - Reset mid-freeze -> outputs 0 immediately.

Source files
------------

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage -- instruction-decode stage of the 5-stage ARM-subset pipeline.
//
// Decodes the fetched instruction, reads two operands from a 16x32 register
// file, evaluates the condition field against the status flags, and registers
// everything into the ID/EX pipeline boundary.
//
// The register file has one write-back port. A write in the same cycle as a
// read of the same index is forwarded to that read.
//
// Ports
//   clk            pipeline clock; all state changes on the rising edge
//   rst            asynchronous, active-low reset
//   freeze         hold the ID/EX register contents
//   flush          load a bubble (all zeros, pc included) into ID/EX
//   hazard         decode the current instruction as a bubble
//   pc_in          PC+4 from fetch
//   instruction    fetched instruction
//   sr             status flags {N,Z,C,V}
//   wb_en/wb_dest/wb_value   register-file write-back port
//   src1, src2, two_src      source indices for the hazard unit (combinational)
//   pc_out .. dest           registered ID/EX outputs
// ---------------------------------------------------------------------------
module id_stage #(
    parameter int NREGS = 16,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            freeze,
    input  logic            flush,
    input  logic            hazard,
    input  logic [XLEN-1:0] pc_in,
    input  logic [31:0]     instruction,
    input  logic [3:0]      sr,
    input  logic            wb_en,
    input  logic [3:0]      wb_dest,
    input  logic [XLEN-1:0] wb_value,
    output logic [3:0]      src1,
    output logic [3:0]      src2,
    output logic            two_src,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] val_rn,
    output logic [XLEN-1:0] val_rm,
    output logic [3:0]      exe_cmd,
    output logic            mem_r_en,
    output logic            mem_w_en,
    output logic            wb_en_out,
    output logic            s_out,
    output logic            b_out,
    output logic            imm_out,
    output logic [11:0]     shift_operand,
    output logic [23:0]     signed_imm_24,
    output logic [3:0]      dest
);

    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    // ---------------------------------------------------------------------
    // Instruction fields
    // ---------------------------------------------------------------------
    logic [3:0] cond;
    logic [1:0] mode;
    logic       i_bit;
    logic [3:0] opcode;
    logic       s_bit;
    logic       mem_w;

    assign cond   = instruction[31:28];
    assign mode   = instruction[27:26];
    assign i_bit  = instruction[25];
    assign opcode = instruction[24:21];
    assign s_bit  = instruction[20];

    // A store needs Rd as its second read port (the data being stored),
    // so the second source index switches from Rm to Rd.
    assign mem_w   = (mode == MODE_MEM) && !s_bit;
    assign src1    = instruction[19:16];
    assign src2    = mem_w ? instruction[15:12] : instruction[3:0];
    assign two_src = ~i_bit | mem_w;

    // ---------------------------------------------------------------------
    // Register file: one flop bank per entry, combinational read
    // ---------------------------------------------------------------------
    logic [XLEN-1:0] rf_q [NREGS];

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_rf
            logic [XLEN-1:0] r_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_reg <= '0;
                end else if (wb_en && (wb_dest == 4'(gi))) begin
                    r_reg <= wb_value;
                end
            end

            assign rf_q[gi] = r_reg;
        end
    endgenerate

    // Write-through bypass: a same-cycle write wins over the stored value.
    logic [XLEN-1:0] rn_next;
    logic [XLEN-1:0] rm_next;

    always_comb begin
        rn_next = rf_q[src1];
        rm_next = rf_q[src2];
        if (wb_en && (wb_dest == src1)) begin
            rn_next = wb_value;
        end
        if (wb_en && (wb_dest == src2)) begin
            rm_next = wb_value;
        end
    end

    // ---------------------------------------------------------------------
    // Condition evaluation
    // ---------------------------------------------------------------------
    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_pass;

    assign {flag_n, flag_z, flag_c, flag_v} = sr;

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = ~flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = ~flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = ~flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = ~flag_v;
            4'b1000: cond_pass = flag_c & ~flag_z;
            4'b1001: cond_pass = ~flag_c | flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_pass = flag_z | (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // ---------------------------------------------------------------------
    // Control decode
    // ---------------------------------------------------------------------
    logic [3:0] dec_exe;
    logic       dec_mr, dec_mw, dec_wb, dec_s, dec_b;

    always_comb begin
        dec_exe = 4'b0000;
        dec_mr  = 1'b0;
        dec_mw  = 1'b0;
        dec_wb  = 1'b0;
        dec_s   = 1'b0;
        dec_b   = 1'b0;
        case (mode)
            MODE_DP: begin
                dec_s  = s_bit;
                dec_wb = 1'b1;
                case (opcode)
                    4'b1101: dec_exe = 4'b0001;                 // MOV
                    4'b1111: dec_exe = 4'b1001;                 // MVN
                    4'b0100: dec_exe = 4'b0010;                 // ADD
                    4'b0101: dec_exe = 4'b0011;                 // ADC
                    4'b0010: dec_exe = 4'b0100;                 // SUB
                    4'b0110: dec_exe = 4'b0101;                 // SBC
                    4'b0000: dec_exe = 4'b0110;                 // AND
                    4'b1100: dec_exe = 4'b0111;                 // ORR
                    4'b0001: dec_exe = 4'b1000;                 // EOR
                    4'b1010: begin                              // CMP
                        dec_exe = 4'b0100;
                        dec_wb  = 1'b0;
                    end
                    4'b1000: begin                              // TST
                        dec_exe = 4'b0110;
                        dec_wb  = 1'b0;
                    end
                    default: dec_exe = 4'b0000;
                endcase
            end
            MODE_MEM: begin
                dec_exe = 4'b0010;      // address = Rn + offset
                dec_mr  = s_bit;        // LDR
                dec_mw  = ~s_bit;       // STR
                dec_wb  = s_bit;
            end
            MODE_BR: begin
                dec_b = 1'b1;
            end
            default: ;
        endcase
    end

    // A failed condition or a hazard turns the instruction into a bubble:
    // only the controls are squashed, the data fields still load.
    logic bubble;
    assign bubble = ~cond_pass | hazard;

    // ---------------------------------------------------------------------
    // ID/EX pipeline register: rst > flush > freeze > load
    // ---------------------------------------------------------------------
    logic [XLEN-1:0] pc_reg, rn_reg, rm_reg;
    logic [3:0]      exe_reg, dest_reg;
    logic            mr_reg, mw_reg, wb_reg, s_reg, b_reg, imm_reg;
    logic [11:0]     shift_reg;
    logic [23:0]     simm_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg    <= '0;
            rn_reg    <= '0;
            rm_reg    <= '0;
            exe_reg   <= '0;
            mr_reg    <= 1'b0;
            mw_reg    <= 1'b0;
            wb_reg    <= 1'b0;
            s_reg     <= 1'b0;
            b_reg     <= 1'b0;
            imm_reg   <= 1'b0;
            shift_reg <= '0;
            simm_reg  <= '0;
            dest_reg  <= '0;
        end else if (flush) begin
            pc_reg    <= '0;
            rn_reg    <= '0;
            rm_reg    <= '0;
            exe_reg   <= '0;
            mr_reg    <= 1'b0;
            mw_reg    <= 1'b0;
            wb_reg    <= 1'b0;
            s_reg     <= 1'b0;
            b_reg     <= 1'b0;
            imm_reg   <= 1'b0;
            shift_reg <= '0;
            simm_reg  <= '0;
            dest_reg  <= '0;
        end else if (!freeze) begin
            pc_reg    <= pc_in;
            rn_reg    <= rn_next;
            rm_reg    <= rm_next;
            exe_reg   <= bubble ? 4'b0000 : dec_exe;
            mr_reg    <= dec_mr & ~bubble;
            mw_reg    <= dec_mw & ~bubble;
            wb_reg    <= dec_wb & ~bubble;
            s_reg     <= dec_s  & ~bubble;
            b_reg     <= dec_b  & ~bubble;
            imm_reg   <= i_bit;
            shift_reg <= instruction[11:0];
            simm_reg  <= instruction[23:0];
            dest_reg  <= instruction[15:12];
        end
    end

    assign pc_out        = pc_reg;
    assign val_rn        = rn_reg;
    assign val_rm        = rm_reg;
    assign exe_cmd       = exe_reg;
    assign mem_r_en      = mr_reg;
    assign mem_w_en      = mw_reg;
    assign wb_en_out     = wb_reg;
    assign s_out         = s_reg;
    assign b_out         = b_reg;
    assign imm_out       = imm_reg;
    assign shift_operand = shift_reg;
    assign signed_imm_24 = simm_reg;
    assign dest          = dest_reg;

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage -- directed scoreboard bench for id_stage.
// Stimulus pushes the expected ID/EX contents after each rising edge; the
// monitor pops and compares on the following falling edge (or on demand for
// the asynchronous reset case).
// ---------------------------------------------------------------------------
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze, flush, hazard;
    logic [31:0] pc_in, instruction;
    logic [3:0]  sr;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic [3:0]  src1, src2;
    logic        two_src;
    logic [31:0] pc_out, val_rn, val_rm;
    logic [3:0]  exe_cmd;
    logic        mem_r_en, mem_w_en, wb_en_out, s_out, b_out, imm_out;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest;

    id_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard(hazard),
        .pc_in(pc_in), .instruction(instruction), .sr(sr),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .src1(src1), .src2(src2), .two_src(two_src),
        .pc_out(pc_out), .val_rn(val_rn), .val_rm(val_rm), .exe_cmd(exe_cmd),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en_out(wb_en_out),
        .s_out(s_out), .b_out(b_out), .imm_out(imm_out),
        .shift_operand(shift_operand), .signed_imm_24(signed_imm_24), .dest(dest)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [145:0] exp;
    } item_t;

    item_t q[$];
    event  sample_ev;
    int    total  = 0;
    int    passed = 0;

    logic [145:0] actual;
    assign actual = {pc_out, val_rn, val_rm, exe_cmd, mem_r_en, mem_w_en,
                     wb_en_out, s_out, b_out, imm_out, shift_operand,
                     signed_imm_24, dest};

    function automatic void chk(input string nm, input logic [145:0] act,
                                input logic [145:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s got=%h exp=%h", nm, act, exp);
    endfunction

    // Expected ID/EX bundle; data fields are the raw instruction slices.
    function automatic logic [145:0] mk(input logic [31:0] pc, vrn, vrm,
                                        input logic [3:0] exe,
                                        input logic mr, mw, wb, s, b, imm,
                                        input logic [31:0] ins);
        return {pc, vrn, vrm, exe, mr, mw, wb, s, b, imm,
                ins[11:0], ins[23:0], ins[15:12]};
    endfunction

    task automatic push(input string nm, input logic [145:0] e);
        item_t it;
        it.name = nm;
        it.exp  = e;
        q.push_back(it);
    endtask

    task automatic tick(input string nm, input logic [145:0] e);
        @(posedge clk);
        push(nm, e);
        #1;
    endtask

    // Monitor: drain every pending expectation at each falling edge.
    initial begin
        item_t it;
        forever begin
            @(negedge clk or sample_ev);
            while (q.size() > 0) begin
                it = q.pop_front();
                chk(it.name, actual, it.exp);
                $display("txn %-14s out=%h", it.name, actual);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  cond_t [11] = '{4'h1, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC,
                                     4'hD, 4'hF, 4'h6, 4'h2, 4'h5};
        logic [3:0]  sr_t   [11] = '{4'b0000, 4'b0010, 4'b0010, 4'b1001,
                                     4'b1000, 4'b0100, 4'b0000, 4'b0000,
                                     4'b0001, 4'b0000, 4'b1000};
        logic        pass_t [11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                                     1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [145:0] fr;
        logic [31:0]  ins;

        rst = 1'b0; freeze = 1'b0; flush = 1'b0; hazard = 1'b0;
        pc_in = 32'h4; instruction = 32'hE3A01005; sr = 4'b0000;
        wb_en = 1'b0; wb_dest = 4'd0; wb_value = 32'h0;
        #1;
        chk("src1_mov", 146'(src1), 146'(4'd0));
        chk("src2_mov", 146'(src2), 146'(4'd5));
        chk("two_src_mov", 146'(two_src), 146'(1'b0));
        tick("reset", '0);

        rst = 1'b1;
        tick("mov", mk(32'h4, 0, 0, 4'b0001, 0, 0, 1, 0, 0, 1, 32'hE3A01005));

        // ADD R1,R2,R3 with R2 written in the same cycle
        pc_in = 32'h8; instruction = 32'hE0821003;
        wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'h1234;
        #1;
        chk("src1_add", 146'(src1), 146'(4'd2));
        chk("src2_add", 146'(src2), 146'(4'd3));
        tick("add_bypass", mk(32'h8, 32'h1234, 0, 4'b0010, 0, 0, 1, 0, 0, 0, 32'hE0821003));

        pc_in = 32'hC; wb_dest = 4'd3; wb_value = 32'hCAFE;
        tick("add_rm_byp", mk(32'hC, 32'h1234, 32'hCAFE, 4'b0010, 0, 0, 1, 0, 0, 0, 32'hE0821003));

        wb_en = 1'b0; pc_in = 32'h10; instruction = 32'h03A01005; sr = 4'b0000;
        tick("moveq_fail", mk(32'h10, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 32'h03A01005));

        pc_in = 32'h14; sr = 4'b0100;
        tick("moveq_pass", mk(32'h14, 0, 0, 4'b0001, 0, 0, 1, 0, 0, 1, 32'h03A01005));

        sr = 4'b0000; pc_in = 32'h18; instruction = 32'hE5821000;
        #1;
        chk("src1_str", 146'(src1), 146'(4'd2));
        chk("src2_str", 146'(src2), 146'(4'd1));
        chk("two_src_str", 146'(two_src), 146'(1'b1));
        tick("str", mk(32'h18, 32'h1234, 0, 4'b0010, 0, 1, 0, 0, 0, 0, 32'hE5821000));

        pc_in = 32'h1C; instruction = 32'hE5921000;
        tick("ldr", mk(32'h1C, 32'h1234, 0, 4'b0010, 1, 0, 1, 0, 0, 0, 32'hE5921000));

        pc_in = 32'h20; instruction = 32'hE1520003;
        tick("cmp", mk(32'h20, 32'h1234, 32'hCAFE, 4'b0100, 0, 0, 0, 1, 0, 0, 32'hE1520003));

        hazard = 1'b1; pc_in = 32'h24; instruction = 32'hE0821003;
        tick("hazard", mk(32'h24, 32'h1234, 32'hCAFE, 4'b0000, 0, 0, 0, 0, 0, 0, 32'hE0821003));
        hazard = 1'b0;

        pc_in = 32'h28; instruction = 32'hEA000010;
        tick("branch", mk(32'h28, 0, 0, 4'b0000, 0, 0, 0, 0, 1, 1, 32'hEA000010));

        // Condition table on MOV R1,#5
        for (int k = 0; k < 11; k++) begin
            ins = {cond_t[k], 28'h3A01005};
            instruction = ins; sr = sr_t[k]; pc_in = 32'h100 + 32'(k * 4);
            tick($sformatf("cond_%h_sr%b", cond_t[k], sr_t[k]),
                 mk(32'h100 + 32'(k * 4), 0, 0, pass_t[k] ? 4'b0001 : 4'b0000,
                    0, 0, pass_t[k], 0, 0, 1, ins));
        end

        // Freeze holds, register writes continue underneath
        sr = 4'b0000; pc_in = 32'h200; instruction = 32'hE3A01005;
        fr = mk(32'h200, 0, 0, 4'b0001, 0, 0, 1, 0, 0, 1, 32'hE3A01005);
        tick("frz_load", fr);
        freeze = 1'b1; pc_in = 32'h204; instruction = 32'hE0821003;
        wb_en = 1'b1; wb_dest = 4'd4; wb_value = 32'h55;
        tick("frz_hold1", fr);
        wb_en = 1'b0; pc_in = 32'h208; instruction = 32'hE5821000;
        tick("frz_hold2", fr);
        flush = 1'b1;
        tick("flush_frz", '0);
        flush = 1'b0; freeze = 1'b0; pc_in = 32'h20C; instruction = 32'hE0841000;
        tick("r4_read", mk(32'h20C, 32'h55, 0, 4'b0010, 0, 0, 1, 0, 0, 0, 32'hE0841000));
        flush = 1'b1;
        tick("flush", '0);
        flush = 1'b0;

        // Asynchronous reset while frozen
        pc_in = 32'h210; instruction = 32'hE3A01005;
        fr = mk(32'h210, 0, 0, 4'b0001, 0, 0, 1, 0, 0, 1, 32'hE3A01005);
        tick("pre_rst", fr);
        freeze = 1'b1;
        tick("frz3", fr);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        push("rst_mid", '0);
        ->sample_ev;
        @(posedge clk);
        #1;
        rst = 1'b1; freeze = 1'b0; pc_in = 32'h214; instruction = 32'hE0821003;
        tick("post_rst_rf", mk(32'h214, 0, 0, 4'b0010, 0, 0, 1, 0, 0, 0, 32'hE0821003));

        @(negedge clk);
        #1;
        chk("drain", 146'(q.size()), 146'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
